// File: rtl/link_tx_arbiter_if.sv
// Handshake bundle between the message sources, the arbiter and the outbound link.
// master: the arbiter side (drives source readies and the link word).
// slave:  the environment side (sources and link sink).
interface link_tx_arbiter_if #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 64
);
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_ready;
    logic [DATA_WIDTH-1:0]         out_data;
    logic                          out_valid;
    logic                          out_ready;

    modport master (
        input  req_data, req_valid, out_ready,
        output req_ready, out_data, out_valid
    );

    modport slave (
        output req_data, req_valid, out_ready,
        input  req_ready, out_data, out_valid
    );
endinterface

// File: rtl/link_tx_arbiter.sv
// Round-robin arbiter sharing one outbound link between NUM_REQ valid/ready sources.
// A grant lasts at most MAX_BURST words; every handover spends one IDLE cycle.
//
//  state | meaning
//  IDLE  | no grant; pick next requester after last_ptr (wrap-around)
//  GRANT | grant_id owns the link until burst limit or it drops valid
module link_tx_arbiter #(
    parameter int NUM_REQ    = 3,
    parameter int DATA_WIDTH = 64,
    parameter int MAX_BURST  = 4,
    localparam int GW        = $clog2(NUM_REQ),
    localparam int BW        = $clog2(MAX_BURST + 1)
) (
    input  logic                  clk,
    input  logic                  reset,
    link_tx_arbiter_if.master     bus,
    output logic [GW-1:0]         grant_id,
    output logic                  busy
);
    typedef enum logic {IDLE, GRANT} state_t;

    state_t                state;
    logic [GW-1:0]         last_ptr;
    logic [GW-1:0]         pick;
    logic [BW-1:0]         burst_cnt;
    logic [DATA_WIDTH-1:0] out_data_r;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  out_valid_r;
    logic                  space;
    logic                  gnt_valid;
    logic                  xfer;
    logic                  release_gnt;
    logic [NUM_REQ-1:0]    ready;

    assign space       = !out_valid_r || bus.out_ready;
    assign gnt_valid   = bus.req_valid[grant_id];
    assign gnt_data    = bus.req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
    assign xfer        = |(bus.req_valid & ready);
    assign release_gnt = (xfer && (burst_cnt == BW'(MAX_BURST - 1))) || (space && !gnt_valid);

    assign bus.req_ready = ready;
    assign bus.out_data  = out_data_r;
    assign bus.out_valid = out_valid_r;
    assign busy          = (state == GRANT) || out_valid_r;

    // Ready goes only to the granted source, and only when the output stage can accept a word.
    always_comb begin
        ready = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if ((state == GRANT) && (grant_id == GW'(i)) && space) begin
                ready[i] = 1'b1;
            end
        end
    end

    // Round-robin search starting just after the last released source.
    always_comb begin
        logic          found;
        logic [GW-1:0] idx;
        pick  = last_ptr;
        found = 1'b0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((int'(last_ptr) + k) % NUM_REQ);
            if (!found && bus.req_valid[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
    end

    // Grant FSM plus the one-entry registered output stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            grant_id    <= '0;
            last_ptr    <= GW'(NUM_REQ - 1);
            burst_cnt   <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
        end else begin
            if (xfer) begin
                out_data_r  <= gnt_data;
                out_valid_r <= 1'b1;
            end else if (bus.out_ready) begin
                out_valid_r <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (|bus.req_valid) begin
                        grant_id  <= pick;
                        burst_cnt <= '0;
                        state     <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        burst_cnt <= burst_cnt + BW'(1);
                    end
                    if (release_gnt) begin
                        state    <= IDLE;
                        last_ptr <= grant_id;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_link_tx_arbiter.sv
// Bench for link_tx_arbiter: per-source word queues drive the inputs, a scoreboard
// queue holds the expected link words, and a monitor compares every consumed word.
module tb_link_tx_arbiter;
    localparam int NR = 3;
    localparam int DW = 64;

    logic       clk;
    logic       reset;
    logic [1:0] grant_id;
    logic       busy;

    link_tx_arbiter_if #(.NUM_REQ(NR), .DATA_WIDTH(DW)) bus ();

    link_tx_arbiter #(.NUM_REQ(NR), .DATA_WIDTH(DW), .MAX_BURST(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .grant_id (grant_id),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int            n_cmp = 0;
    int            n_err = 0;
    int            cyc   = 0;
    logic [63:0]   src_q [NR][$];
    logic [63:0]   exp_q [$];
    int            stamp_q [$];
    logic [NR-1:0] hs;

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] word(int s, int t, int n);
        return {4'(s), 4'(t), 56'(n)};
    endfunction

    always @(posedge clk) cyc++;

    // Handshakes are sampled mid-cycle, where all inputs are settled.
    always @(negedge clk) hs = bus.req_valid & bus.req_ready;

    // Sources: present the head word, pop it once it has been accepted.
    always @(posedge clk) begin
        logic [NR*DW-1:0] d;
        logic [NR-1:0]    v;
        #1;
        for (int i = 0; i < NR; i++) begin
            if (reset && hs[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
        end
        d = '0;
        v = '0;
        for (int i = 0; i < NR; i++) begin
            if (src_q[i].size() > 0) begin
                v[i]             = 1'b1;
                d[i*DW +: DW]    = src_q[i][0];
            end
        end
        bus.req_valid = v;
        bus.req_data  = d;
    end

    // Monitor: every word the link consumes must be the next expected one.
    always @(negedge clk) begin
        if (reset && bus.out_valid && bus.out_ready) begin
            stamp_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_word: got %0h expected none", bus.out_data);
            end else begin
                check("link_word", bus.out_data, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(int s, logic [63:0] w);
        src_q[s].push_back(w);
    endtask

    task automatic drain(string name, int budget);
        int n = 0;
        while ((src_q[0].size() + src_q[1].size() + src_q[2].size() + exp_q.size() > 0
                || bus.out_valid) && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL %s_timeout: got %0d pending words expected 0", name, exp_q.size());
        end
    endtask

    task automatic wait_ready(string name, int budget);
        int n = 0;
        while (bus.req_ready == '0 && n < budget) begin
            tick();
            n++;
        end
        n_cmp++;
        if (n >= budget) begin
            n_err++;
            $display("FAIL %s_timeout: got no grant expected a grant", name);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        logic [63:0] held;
        logic [1:0]  gid0;
        logic [NR-1:0] rr_or;
        logic        gid_moved;
        int          n;

        reset         = 1'b0;
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.out_ready = 1'b1;

        // 1: reset held with every source requesting
        for (int s = 0; s < NR; s++) send(s, word(s, 1, 0));
        for (int s = 0; s < NR; s++) exp_q.push_back(word(s, 1, 0));
        tick(); tick(); tick();
        check("rst_req_valid_all", 64'(bus.req_valid), 64'h7);
        check("rst_out_valid", 64'(bus.out_valid), 64'h0);
        check("rst_req_ready", 64'(bus.req_ready), 64'h0);
        check("rst_busy", 64'(busy), 64'h0);
        reset = 1'b1;
        tick();
        check("rst_first_grant", 64'(grant_id), 64'h0);
        check("rst_busy_after", 64'(busy), 64'h1);
        drain("t1", 60);

        // 2: single source, two words, 1-cycle latency
        send(1, word(1, 2, 0));
        send(1, word(1, 2, 1));
        exp_q.push_back(word(1, 2, 0));
        exp_q.push_back(word(1, 2, 1));
        n = 0;
        while (!(bus.req_valid[1] && bus.req_ready[1]) && n < 20) begin tick(); n++; end
        check("t2_granted", 64'(bus.req_ready), 64'h2);
        tick();
        check("t2_word_a_valid", 64'(bus.out_valid), 64'h1);
        check("t2_word_a", bus.out_data, word(1, 2, 0));
        tick();
        check("t2_word_b", bus.out_data, word(1, 2, 1));
        check("t2_grant_id", 64'(grant_id), 64'h1);
        drain("t2", 40);
        check("t2_grant_hold", 64'(grant_id), 64'h1);
        check("t2_idle_busy", 64'(busy), 64'h0);

        // 3: fairness, all three streaming 8 words each
        pulse_reset();
        stamp_q.delete();
        for (int s = 0; s < NR; s++)
            for (int k = 0; k < 8; k++) send(s, word(s, 3, k));
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NR; s++)
                for (int k = 0; k < 4; k++) exp_q.push_back(word(s, 3, r*4 + k));
        drain("t3", 200);
        check("t3_word_count", 64'(stamp_q.size()), 64'd24);
        if (stamp_q.size() == 24) begin
            check("t3_span", 64'(stamp_q[23] - stamp_q[0]), 64'd28);
            check("t3_in_burst_gap", 64'(stamp_q[3] - stamp_q[2]), 64'd1);
            check("t3_handover_gap", 64'(stamp_q[4] - stamp_q[3]), 64'd2);
        end

        // 4: backpressure mid-burst
        stamp_q.delete();
        for (int k = 0; k < 8; k++) send(0, word(0, 4, k));
        for (int k = 0; k < 4; k++) send(1, word(1, 4, k));
        for (int k = 0; k < 4; k++) exp_q.push_back(word(0, 4, k));
        for (int k = 0; k < 4; k++) exp_q.push_back(word(1, 4, k));
        for (int k = 4; k < 8; k++) exp_q.push_back(word(0, 4, k));
        n = 0;
        while (stamp_q.size() < 2 && n < 40) begin tick(); n++; end
        check("t4_started", 64'(stamp_q.size() >= 2), 64'h1);
        bus.out_ready = 1'b0;
        tick();
        held      = bus.out_data;
        gid0      = grant_id;
        rr_or     = '0;
        gid_moved = 1'b0;
        check("t4_held_valid", 64'(bus.out_valid), 64'h1);
        for (int c = 0; c < 10; c++) begin
            tick();
            check("t4_out_data_stable", bus.out_data, held);
            rr_or = rr_or | bus.req_ready;
            if (grant_id != gid0) gid_moved = 1'b1;
        end
        check("t4_req_ready_low", 64'(rr_or), 64'h0);
        check("t4_grant_kept", 64'(gid_moved), 64'h0);
        check("t4_grant_src0", 64'(gid0), 64'h0);
        bus.out_ready = 1'b1;
        drain("t4", 100);

        // 5: early release of src2, src0 waiting
        send(2, word(2, 5, 0));
        send(0, word(0, 5, 0));
        send(0, word(0, 5, 1));
        exp_q.push_back(word(2, 5, 0));
        exp_q.push_back(word(0, 5, 0));
        exp_q.push_back(word(0, 5, 1));
        wait_ready("t5_first", 20);
        check("t5_first_grant", 64'(grant_id), 64'h2);
        drain("t5", 60);
        check("t5_next_grant", 64'(grant_id), 64'h0);

        // 6: reset during a stalled burst
        for (int k = 0; k < 4; k++) send(1, word(1, 6, k));
        n = 0;
        while (!bus.out_valid && n < 20) begin tick(); n++; end
        check("t6_loaded", 64'(bus.out_valid), 64'h1);
        bus.out_ready = 1'b0;
        tick();
        reset = 1'b0;
        #1;
        check("t6_async_out_valid", 64'(bus.out_valid), 64'h0);
        check("t6_async_busy", 64'(busy), 64'h0);
        check("t6_async_req_ready", 64'(bus.req_ready), 64'h0);
        src_q[1].delete();
        exp_q.delete();
        tick();
        bus.out_ready = 1'b1;
        send(2, word(2, 6, 9));
        send(0, word(0, 6, 9));
        exp_q.push_back(word(0, 6, 9));
        exp_q.push_back(word(2, 6, 9));
        tick();
        tick();
        reset = 1'b1;
        tick();
        check("t6_restart_grant", 64'(grant_id), 64'h0);
        drain("t6", 60);
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
